// File: rtl/seq_chunk_adder.sv
// ----------------------------------------------------------------------------
// seq_chunk_adder
//
// Purpose:
//   Multi-cycle ripple-carry adder/subtractor. The WIDTH-bit operands are
//   summed CHUNK bits per clock. The carry is held in a register between
//   chunks, so the critical path is only one CHUNK-bit adder deep. A single
//   operation takes N = WIDTH/CHUNK chunk cycles. It uses a start/busy/done
//   handshake. The result, carry-out and signed overflow are held from done
//   until the next accepted operation.
//
// Ports:
//   clk    in   1      rising-edge clock
//   rst_n  in   1      synchronous, active-low reset
//   start  in   1      request; accepted only while busy=0
//   a      in   WIDTH  operand A, sampled on the accepting edge
//   b      in   WIDTH  operand B, sampled on the accepting edge
//   c_in   in   1      carry-in (add) / borrow-in (sub)
//   sub    in   1      0: s = a + b + c_in ; 1: s = a - b - c_in
//   busy   out  1      operation in progress
//   done   out  1      one-cycle pulse, s/c_out/ovf valid
//   s      out  WIDTH  result (mod 2^WIDTH)
//   c_out  out  1      carry out of MSB (sub: 1 = no borrow)
//   ovf    out  1      two's-complement overflow
// ----------------------------------------------------------------------------
module seq_chunk_adder #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             c_out,
    output logic             ovf
);

    localparam int N     = WIDTH / CHUNK;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    // A chunk size that does not tile the operand would silently drop bits.
    // Refuse to elaborate instead.
    if ((WIDTH % CHUNK) != 0) begin : g_bad_chunk
        $error("seq_chunk_adder: WIDTH (%0d) must be a multiple of CHUNK (%0d)",
               WIDTH, CHUNK);
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   s_q, s_d;
    logic               c_out_q, c_out_d;
    logic               ovf_q, ovf_d;
    logic [IDX_W-1:0]   idx_q, idx_d;

    logic [CHUNK-1:0]   a_chunk;
    logic [CHUNK-1:0]   b_chunk;
    logic [CHUNK:0]     chunk_sum;
    logic               msb_cin;

    assign a_chunk   = a_q[idx_q*CHUNK +: CHUNK];
    assign b_chunk   = b_q[idx_q*CHUNK +: CHUNK];
    assign chunk_sum = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_q};

    // The carry into the top bit of the chunk is recovered from the top bit of
    // the sum, because sum = a ^ b ^ cin. This avoids a second adder for the
    // lower CHUNK-1 bits. It also works for CHUNK=1.
    assign msb_cin = a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1] ^ chunk_sum[CHUNK-1];

    // Next-state and datapath update.
    // Subtraction is a + ~b + 1. Folding sub into both the inverted B operand
    // and the initial carry makes borrow-in become (c_in ^ sub).
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        s_d     = s_q;
        c_out_d = c_out_q;
        ovf_d   = ovf_q;
        idx_d   = idx_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    carry_d = c_in ^ sub;
                    s_d     = '0;
                    idx_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                s_d[idx_q*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
                carry_d = chunk_sum[CHUNK];
                if (idx_q == IDX_W'(N - 1)) begin
                    c_out_d = chunk_sum[CHUNK];
                    ovf_d   = msb_cin ^ chunk_sum[CHUNK];
                    idx_d   = '0;
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers. The reset also aborts an operation that
    // is in flight, so no done pulse follows it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            s_q     <= '0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            s_q     <= s_d;
            c_out_q <= c_out_d;
            ovf_q   <= ovf_d;
            idx_q   <= idx_d;
        end
    end

    assign busy  = (state_q == RUN);
    assign done  = (state_q == DONE);
    assign s     = s_q;
    assign c_out = c_out_q;
    assign ovf   = ovf_q;

endmodule

// File: tb/tb_seq_chunk_adder.sv
// ----------------------------------------------------------------------------
// tb_seq_chunk_adder
//
// Drives two instances of the chunked adder. The first is 8 bits in 4-bit
// chunks (N=2). The second is 32 bits in 8-bit chunks (N=4). The 8-bit
// instance runs a table of hand-computed vectors. The 32-bit instance runs
// hand-written sequences: mid-run start, reset abort and back-to-back
// operation. Reference results come from a full-width add model.
// ----------------------------------------------------------------------------
module tb_seq_chunk_adder;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        start8, cin8, sub8, busy8, done8, cout8, ovf8;
    logic [7:0]  a8, b8, s8;

    logic        start32, cin32, sub32, busy32, done32, cout32, ovf32;
    logic [31:0] a32, b32, s32;

    int n_checks = 0;
    int n_fail   = 0;

    seq_chunk_adder #(.WIDTH(8), .CHUNK(4)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
        .c_in(cin8), .sub(sub8), .busy(busy8), .done(done8), .s(s8),
        .c_out(cout8), .ovf(ovf8)
    );

    seq_chunk_adder #(.WIDTH(32), .CHUNK(8)) dut32 (
        .clk(clk), .rst_n(rst_n), .start(start32), .a(a32), .b(b32),
        .c_in(cin32), .sub(sub32), .busy(busy32), .done(done32), .s(s32),
        .c_out(cout32), .ovf(ovf32)
    );

    // Free-running clock with a 10 ns period
    always #5 clk = ~clk;

    // Stop a run that has hung
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic       sub;
        logic [7:0] s;
        logic       c;
        logic       o;
    } vec_t;

    // Full-width reference. Result is {ovf, c_out, s}. The carry into the
    // MSB comes from a separate sum of the lower bits.
    function automatic logic [9:0] model8(input logic [7:0] a, input logic [7:0] b,
                                          input logic cin, input logic sub);
        logic [7:0] bb;
        logic       ci;
        logic [8:0] full;
        logic [7:0] low;
        bb   = sub ? ~b : b;
        ci   = cin ^ sub;
        full = {1'b0, a} + {1'b0, bb} + {8'd0, ci};
        low  = {1'b0, a[6:0]} + {1'b0, bb[6:0]} + {7'd0, ci};
        return {low[7] ^ full[8], full[8], full[7:0]};
    endfunction

    function automatic logic [33:0] model32(input logic [31:0] a, input logic [31:0] b,
                                            input logic cin, input logic sub);
        logic [31:0] bb;
        logic        ci;
        logic [32:0] full;
        logic [31:0] low;
        bb   = sub ? ~b : b;
        ci   = cin ^ sub;
        full = {1'b0, a} + {1'b0, bb} + {32'd0, ci};
        low  = {1'b0, a[30:0]} + {1'b0, bb[30:0]} + {31'd0, ci};
        return {low[31] ^ full[32], full[32], full[31:0]};
    endfunction

    // Compare one value and count it
    task automatic checkOutput(input string name, input logic [63:0] act,
                               input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
        end
    endtask

    // Issue one op on the 8-bit instance and wait for done.
    // lat counts negedges from the start assertion. Done is expected at
    // lat = N+1 (the accepting edge plus N chunk edges). A timeout returns
    // lat = 99, which fails the latency check.
    task automatic applyStimulus8(input logic [7:0] a, input logic [7:0] b,
                                  input logic cin, input logic sub,
                                  output logic [7:0] s_o, output logic c_o,
                                  output logic o_o, output int lat);
        @(negedge clk);
        a8 = a; b8 = b; cin8 = cin; sub8 = sub; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        lat = 1;
        while (!done8 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (!done8) lat = 99;
        s_o = s8; c_o = cout8; o_o = ovf8;
    endtask

    task automatic applyStimulus32(input logic [31:0] a, input logic [31:0] b,
                                   input logic cin, input logic sub,
                                   output logic [31:0] s_o, output logic c_o,
                                   output logic o_o, output int lat);
        @(negedge clk);
        a32 = a; b32 = b; cin32 = cin; sub32 = sub; start32 = 1'b1;
        @(negedge clk);
        start32 = 1'b0;
        lat = 1;
        while (!done32 && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        if (!done32) lat = 99;
        s_o = s32; c_o = cout32; o_o = ovf32;
    endtask

    initial begin
        vec_t        vecs[10];
        logic [7:0]  g8;
        logic [31:0] g32;
        logic        gc, go;
        logic [9:0]  e8;
        logic [33:0] e32;
        int          lat, cyc, last, k, seen;
        logic [31:0] ra[4], rb[4];
        logic        rc[4], rs[4];

        // Hand-computed vectors {a, b, c_in, sub, s, c_out, ovf}
        vecs[0] = '{8'd109, 8'd102, 1'b0, 1'b0, 8'd211, 1'b0, 1'b1};
        vecs[1] = '{8'd113, 8'd102, 1'b1, 1'b0, 8'd216, 1'b0, 1'b1};
        vecs[2] = '{8'd243, 8'd15,  1'b0, 1'b0, 8'd2,   1'b1, 1'b0};
        vecs[3] = '{8'd240, 8'd160, 1'b0, 1'b0, 8'd144, 1'b1, 1'b0};
        vecs[4] = '{8'd5,   8'd7,   1'b0, 1'b1, 8'd254, 1'b0, 1'b0};
        vecs[5] = '{8'd128, 8'd1,   1'b0, 1'b1, 8'd127, 1'b1, 1'b1};
        vecs[6] = '{8'd100, 8'd100, 1'b1, 1'b1, 8'd255, 1'b0, 1'b0};
        vecs[7] = '{8'd0,   8'd0,   1'b0, 1'b0, 8'd0,   1'b0, 1'b0};
        vecs[8] = '{8'd127, 8'd1,   1'b0, 1'b0, 8'd128, 1'b0, 1'b1};
        vecs[9] = '{8'd0,   8'd0,   1'b0, 1'b1, 8'd0,   1'b1, 1'b0};

        rst_n = 1'b0;
        start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = 1'b0;
        start32 = 1'b0; a32 = '0; b32 = '0; cin32 = 1'b0; sub32 = 1'b0;

        // Reset state of both instances
        repeat (3) @(negedge clk);
        checkOutput("reset dut8 busy/done/s/c/ovf", {busy8, done8, s8, cout8, ovf8}, 64'd0);
        checkOutput("reset dut32 busy/done/s/c/ovf", {busy32, done32, s32, cout32, ovf32}, 64'd0);
        rst_n = 1'b1;

        // Table of 8-bit vectors, each checked for result and latency
        for (int i = 0; i < 10; i++) begin
            applyStimulus8(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, g8, gc, go, lat);
            checkOutput($sformatf("vec%0d latency", i), 64'(lat), 64'd3);
            checkOutput($sformatf("vec%0d s", i), 64'(g8), 64'(vecs[i].s));
            checkOutput($sformatf("vec%0d c_out", i), 64'(gc), 64'(vecs[i].c));
            checkOutput($sformatf("vec%0d ovf", i), 64'(go), 64'(vecs[i].o));
        end

        // Done is a single-cycle pulse, and the result holds afterwards
        @(negedge clk);
        checkOutput("dut8 done pulse width", {busy8, done8}, 64'd0);
        checkOutput("dut8 result held", {s8, cout8, ovf8}, {8'd0, 1'b1, 1'b0});

        // Random 8-bit ops against the model
        for (int i = 0; i < 6; i++) begin
            logic [7:0] ra8, rb8;
            logic       rci, rsu;
            ra8 = 8'($urandom); rb8 = 8'($urandom);
            rci = 1'($urandom); rsu = 1'($urandom);
            e8 = model8(ra8, rb8, rci, rsu);
            applyStimulus8(ra8, rb8, rci, rsu, g8, gc, go, lat);
            checkOutput($sformatf("rand8 %0d {ovf,c,s}", i), 64'({go, gc, g8}), 64'(e8));
        end

        // 32-bit carry through all chunks. A start pulse in mid-run is ignored.
        @(negedge clk);
        a32 = 32'hFFFF_FFFF; b32 = 32'd0; cin32 = 1'b1; sub32 = 1'b0; start32 = 1'b1;
        @(negedge clk);
        start32 = 1'b0;
        cyc = 1;
        @(negedge clk);
        cyc++;
        a32 = 32'd1; b32 = 32'd1; cin32 = 1'b0; start32 = 1'b1;
        @(negedge clk);
        cyc++;
        start32 = 1'b0;
        while (!done32 && cyc < 30) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput("wrap latency", 64'(cyc), 64'd5);
        checkOutput("wrap s", 64'(s32), 64'd0);
        checkOutput("wrap c_out/ovf", {cout32, ovf32}, 64'b10);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (busy32 || done32) seen++;
        end
        checkOutput("mid-run start not queued", 64'(seen), 64'd0);

        // Reset asserted during chunk 2 of 4 aborts the op
        @(negedge clk);
        a32 = 32'h1234_5678; b32 = 32'h1111_1111; cin32 = 1'b0; sub32 = 1'b0; start32 = 1'b1;
        @(negedge clk);
        start32 = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("abort busy/done/s/c/ovf", {busy32, done32, s32, cout32, ovf32}, 64'd0);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done32) seen++;
        end
        checkOutput("no done after abort", 64'(seen), 64'd0);
        applyStimulus32(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, g32, gc, go, lat);
        checkOutput("post-abort latency", 64'(lat), 64'd5);
        checkOutput("post-abort {ovf,c,s}", 64'({go, gc, g32}), {30'd0, 2'b00, 32'h2345_6789});

        // Back-to-back ops with start held high. Done is expected every 5th cycle.
        for (int i = 0; i < 4; i++) begin
            ra[i] = $urandom; rb[i] = $urandom;
            rc[i] = 1'($urandom); rs[i] = 1'($urandom);
        end
        @(negedge clk);
        a32 = ra[0]; b32 = rb[0]; cin32 = rc[0]; sub32 = rs[0]; start32 = 1'b1;
        k = 0; cyc = 0; last = 0;
        while (k < 4 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (done32) begin
                e32 = model32(ra[k], rb[k], rc[k], rs[k]);
                checkOutput($sformatf("b2b %0d {ovf,c,s}", k), 64'({ovf32, cout32, s32}), 64'(e32));
                checkOutput($sformatf("b2b %0d spacing", k), 64'(cyc - last), 64'd5);
                last = cyc;
                k++;
                if (k < 4) begin
                    a32 = ra[k]; b32 = rb[k]; cin32 = rc[k]; sub32 = rs[k];
                end else begin
                    start32 = 1'b0;
                end
            end
        end
        start32 = 1'b0;
        checkOutput("b2b ops completed", 64'(k), 64'd4);

        // Subtract with borrow on the wide instance
        applyStimulus32(32'd0, 32'd1, 1'b0, 1'b1, g32, gc, go, lat);
        checkOutput("sub32 0-1 {ovf,c,s}", 64'({go, gc, g32}), {30'd0, 2'b00, 32'hFFFF_FFFF});

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
